// File: rtl/sdtw_stream_array_if.sv
// rtl/sdtw_stream_array_if.sv - job control, query/reference streams and result bundle for sdtw_stream_array
//
// Signals (slave = the alignment engine):
//   start, q_len, r_len          job request and its lengths
//   q_data, q_valid, q_ready     query sample stream
//   r_data, r_valid, r_ready     reference sample stream
//   busy, done, err              job status
//   min_val, min_pos             best cost and 0-based end position
//   stall_cycles                 only when SDTW_STALL_CNT_EN is defined
interface sdtw_stream_array_if #(
    parameter int WIDTH = 16,
    parameter int QLW   = 9
);
    logic             start;
    logic [QLW-1:0]   q_len;
    logic [31:0]      r_len;
    logic [WIDTH-1:0] q_data;
    logic             q_valid;
    logic             q_ready;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_ready;
    logic             busy;
    logic             done;
    logic             err;
    logic [WIDTH-1:0] min_val;
    logic [31:0]      min_pos;
`ifdef SDTW_STALL_CNT_EN
    logic [31:0]      stall_cycles;
`endif

    modport master (
        output start, q_len, r_len, q_data, q_valid, r_data, r_valid,
        input  q_ready, r_ready, busy, done, err, min_val, min_pos
`ifdef SDTW_STALL_CNT_EN
        , input stall_cycles
`endif
    );

    modport slave (
        input  start, q_len, r_len, q_data, q_valid, r_data, r_valid,
        output q_ready, r_ready, busy, done, err, min_val, min_pos
`ifdef SDTW_STALL_CNT_EN
        , output stall_cycles
`endif
    );
endinterface

// File: rtl/sdtw_stream_array.sv
// rtl/sdtw_stream_array.sv - subsequence-DTW systolic array with streamed query/reference and min tracking
//
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   io         sdtw_stream_array_if.slave: start/q_len/r_len job request, q_* and r_* valid/ready
//              streams, busy/done/err status, min_val/min_pos result
// Optional: define SDTW_STALL_CNT_EN to add io.stall_cycles (STREAM cycles with r_valid low).
module sdtw_stream_array #(
    parameter int WIDTH    = 16,
    parameter int MAX_QLEN = 256,
    parameter int QLW      = $clog2(MAX_QLEN + 1)
) (
    input logic clk,
    input logic rst,
    sdtw_stream_array_if.slave io
);
    localparam logic [WIDTH-1:0] INF = '1;

    typedef enum logic [1:0] {IDLE, LOADQ, STREAM, DRAIN} state_t;

    state_t           state_q;
    logic [QLW-1:0]   qlen_q, qcnt_q, dcnt_q;
    logic [31:0]      rlen_q, rcnt_q, col_q, best_pos_q, min_pos_q;
    logic [WIDTH-1:0] best_val_q, min_val_q;
    logic             q_ready_q, r_ready_q, busy_q, done_q, err_q;
`ifdef SDTW_STALL_CNT_EN
    logic [31:0]      stall_q;
`endif

    // PE k holds its query sample, its last cost D[k][j-1], the upstream cost seen one step
    // earlier (diagonal term), the reference sample it consumed and whether that column was real.
    logic [WIDTH-1:0] qry_q [1:MAX_QLEN];
    logic [WIDTH-1:0] qry_d [1:MAX_QLEN];
    logic [WIDTH-1:0] d_q   [1:MAX_QLEN];
    logic [WIDTH-1:0] d_d   [1:MAX_QLEN];
    logic [WIDTH-1:0] dg_q  [1:MAX_QLEN];
    logic [WIDTH-1:0] dg_d  [1:MAX_QLEN];
    logic [WIDTH-1:0] r_q   [1:MAX_QLEN];
    logic [WIDTH-1:0] r_d   [1:MAX_QLEN];
    logic             v_q   [1:MAX_QLEN];
    logic             v_d   [1:MAX_QLEN];
    logic [WIDTH-1:0] up    [1:MAX_QLEN];
    logic [WIDTH-1:0] r_in  [1:MAX_QLEN];
    logic             v_in  [1:MAX_QLEN];

    logic             q_hs, r_hs, start_ok, clear, advance, tap_v;
    logic [WIDTH-1:0] tap_val;

    assign q_hs     = io.q_valid & q_ready_q;
    assign r_hs     = io.r_valid & r_ready_q;
    assign start_ok = (io.q_len != '0) && (io.q_len <= QLW'(MAX_QLEN)) && (io.r_len != 32'd0);
    assign clear    = (state_q == IDLE) && io.start && start_ok;
    // Stalls in STREAM freeze the whole array; DRAIN pushes bubbles every cycle.
    assign advance  = r_hs || (state_q == DRAIN);

    function automatic logic [WIDTH-1:0] pe_cost(input logic [WIDTH-1:0] q, input logic [WIDTH-1:0] r,
                                                 input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                 input logic [WIDTH-1:0] c);
        logic [WIDTH-1:0] ad, m;
        logic [WIDTH:0]   s;
        ad = (q > r) ? (q - r) : (r - q);
        m  = a;
        if (b < m) m = b;
        if (c < m) m = c;
        s = {1'b0, ad} + {1'b0, m};
        return s[WIDTH] ? INF : s[WIDTH-1:0];
    endfunction

    // Row 0 is all zeros, so PE 1 sees a constant 0 above it (and, one step later, diagonally).
    always_comb begin
        up[1]   = '0;
        r_in[1] = io.r_data;
        v_in[1] = r_hs;
        for (int k = 2; k <= MAX_QLEN; k++) begin
            up[k]   = d_q[k-1];
            r_in[k] = r_q[k-1];
            v_in[k] = v_q[k-1];
        end
    end

    always_comb begin
        for (int k = 1; k <= MAX_QLEN; k++) begin
            qry_d[k] = qry_q[k];
            d_d[k]   = d_q[k];
            dg_d[k]  = dg_q[k];
            r_d[k]   = r_q[k];
            v_d[k]   = v_q[k];
            if (q_hs && (qcnt_q == QLW'(k - 1)))
                qry_d[k] = io.q_data;
            if (clear) begin
                d_d[k]  = INF;
                dg_d[k] = INF;
                v_d[k]  = 1'b0;
            end else if (advance) begin
                // Cleared INF state doubles as the D[i][0] boundary; bubbles and PEs past q_len stay INF.
                r_d[k]  = r_in[k];
                dg_d[k] = up[k];
                v_d[k]  = v_in[k] && (QLW'(k) <= qlen_q);
                d_d[k]  = (v_in[k] && (QLW'(k) <= qlen_q)) ?
                          pe_cost(qry_q[k], r_in[k], up[k], dg_q[k], d_q[k]) : INF;
            end
        end
    end

    always_comb begin
        tap_val = INF;
        tap_v   = 1'b0;
        for (int k = 1; k <= MAX_QLEN; k++) begin
            if (qlen_q == QLW'(k)) begin
                tap_val = d_q[k];
                tap_v   = v_q[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 1; k <= MAX_QLEN; k++) begin
            if (rst) begin
                qry_q[k] <= INF;
                d_q[k]   <= INF;
                dg_q[k]  <= INF;
                r_q[k]   <= INF;
                v_q[k]   <= 1'b0;
            end else begin
                qry_q[k] <= qry_d[k];
                d_q[k]   <= d_d[k];
                dg_q[k]  <= dg_d[k];
                r_q[k]   <= r_d[k];
                v_q[k]   <= v_d[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            qlen_q     <= '0;
            qcnt_q     <= '0;
            dcnt_q     <= '0;
            rlen_q     <= '0;
            rcnt_q     <= '0;
            col_q      <= '0;
            best_val_q <= INF;
            best_pos_q <= '0;
            min_val_q  <= INF;
            min_pos_q  <= '0;
            q_ready_q  <= 1'b0;
            r_ready_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef SDTW_STALL_CNT_EN
            stall_q    <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            // Column col_q+1 leaves PE q_len; the first one seeds, later ones must be strictly better.
            if (advance && tap_v) begin
                col_q <= col_q + 32'd1;
                if ((col_q == 32'd0) || (tap_val < best_val_q)) begin
                    best_val_q <= tap_val;
                    best_pos_q <= col_q;
                end
            end
            case (state_q)
                IDLE: begin
                    if (io.start) begin
                        if (start_ok) begin
                            qlen_q     <= io.q_len;
                            rlen_q     <= io.r_len;
                            qcnt_q     <= '0;
                            rcnt_q     <= '0;
                            dcnt_q     <= '0;
                            col_q      <= '0;
                            best_val_q <= INF;
                            best_pos_q <= '0;
                            min_val_q  <= INF;
                            min_pos_q  <= '0;
                            q_ready_q  <= 1'b1;
                            busy_q     <= 1'b1;
                            state_q    <= LOADQ;
`ifdef SDTW_STALL_CNT_EN
                            stall_q    <= '0;
`endif
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                LOADQ: begin
                    if (q_hs) begin
                        qcnt_q <= qcnt_q + 1'b1;
                        if (qcnt_q == qlen_q - 1'b1) begin
                            q_ready_q <= 1'b0;
                            r_ready_q <= 1'b1;
                            state_q   <= STREAM;
                        end
                    end
                end
                STREAM: begin
                    if (r_hs) begin
                        rcnt_q <= rcnt_q + 32'd1;
                        if (rcnt_q == rlen_q - 32'd1) begin
                            r_ready_q <= 1'b0;
                            state_q   <= DRAIN;
                        end
                    end
`ifdef SDTW_STALL_CNT_EN
                    if (!io.r_valid && (stall_q != '1))
                        stall_q <= stall_q + 32'd1;
`endif
                end
                DRAIN: begin
                    // Last column reaches the tap after q_len-1 drain steps and is compared on the next.
                    if (dcnt_q == qlen_q) begin
                        done_q    <= 1'b1;
                        min_val_q <= best_val_q;
                        min_pos_q <= best_pos_q;
                        busy_q    <= 1'b0;
                        state_q   <= IDLE;
                    end else begin
                        dcnt_q <= dcnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign io.q_ready = q_ready_q;
    assign io.r_ready = r_ready_q;
    assign io.busy    = busy_q;
    assign io.done    = done_q;
    assign io.err     = err_q;
    assign io.min_val = min_val_q;
    assign io.min_pos = min_pos_q;
`ifdef SDTW_STALL_CNT_EN
    assign io.stall_cycles = stall_q;
`endif
endmodule

// File: tb/tb_sdtw_stream_array.sv
// tb/tb_sdtw_stream_array.sv - directed self-checking bench for sdtw_stream_array
module tb_sdtw_stream_array;
    localparam int WIDTH    = 8;
    localparam int MAX_QLEN = 4;
    localparam int QLW      = $clog2(MAX_QLEN + 1);
    localparam logic [WIDTH-1:0] INF = '1;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;
    int   done_cnt = 0;
    int   err_cnt = 0;

    logic [WIDTH-1:0] qv [4];
    logic [WIDTH-1:0] rv [8];
    int               gv [8];

    sdtw_stream_array_if #(.WIDTH(WIDTH), .QLW(QLW)) bus ();
    sdtw_stream_array #(.WIDTH(WIDTH), .MAX_QLEN(MAX_QLEN), .QLW(QLW)) dut (
        .clk(clk),
        .rst(rst),
        .io (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.done === 1'b1) done_cnt++;
        if (bus.err === 1'b1) err_cnt++;
    end

    task automatic idle_inputs();
        bus.start = 0; bus.q_len = '0; bus.r_len = '0;
        bus.q_data = '0; bus.q_valid = 0; bus.r_data = '0; bus.r_valid = 0;
    endtask

    task automatic clear_gaps();
        for (int i = 0; i < 8; i++) gv[i] = 0;
    endtask

    task automatic set_basic();
        qv = '{8'd1, 8'd2, 8'd3, 8'd0};
        rv = '{8'd5, 8'd1, 8'd2, 8'd3, 8'd9, 8'd0, 8'd0, 8'd0};
        clear_gaps();
    endtask

    task automatic do_start(input int ql, input int rl);
        bus.start = 1; bus.q_len = QLW'(ql); bus.r_len = rl;
        @(negedge clk);
        bus.start = 0;
    endtask

    task automatic load_q(input int n, input int gap, output bit ok);
        int t;
        t = 0; ok = 1;
        while (bus.q_ready !== 1'b1) begin
            if (t++ > 20) begin ok = 0; return; end
            @(negedge clk);
        end
        repeat (gap) @(negedge clk);
        for (int i = 0; i < n; i++) begin
            bus.q_valid = 1; bus.q_data = qv[i];
            @(negedge clk);
        end
        bus.q_valid = 0;
    endtask

    task automatic send_refs(input int n, output bit ok);
        int t;
        t = 0; ok = 1;
        while (bus.r_ready !== 1'b1) begin
            if (t++ > 20) begin ok = 0; return; end
            @(negedge clk);
        end
        for (int i = 0; i < n; i++) begin
            bus.r_valid = 0;
            repeat (gv[i]) @(negedge clk);
            bus.r_valid = 1; bus.r_data = rv[i];
            @(negedge clk);
        end
        bus.r_valid = 0;
    endtask

    // Called at the first negedge after the final reference handshake; that negedge counts as 1.
    task automatic wait_done(output int lat);
        lat = 1;
        while (bus.done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1; idle_inputs();
        repeat (2) @(negedge clk);
        rst = 0;
        @(negedge clk);
        checks++; if (bus.q_ready !== 1'b0) begin failures++; $display("FAIL reset_q_ready got=%b exp=0", bus.q_ready); end
        checks++; if (bus.r_ready !== 1'b0) begin failures++; $display("FAIL reset_r_ready got=%b exp=0", bus.r_ready); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", bus.err); end
        checks++; if (bus.min_val !== INF) begin failures++; $display("FAIL reset_min_val got=%0d exp=%0d", bus.min_val, INF); end
        checks++; if (bus.min_pos !== 32'd0) begin failures++; $display("FAIL reset_min_pos got=%0d exp=0", bus.min_pos); end
    endtask

    task automatic test_basic_match();
        bit ok; int lat, d0;
        set_basic();
        do_start(3, 5);
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b exp=1", bus.busy); end
        load_q(3, 0, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL basic_q_ready_timeout got=%b exp=1", ok); end
        d0 = done_cnt;
        send_refs(5, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL basic_r_ready_timeout got=%b exp=1", ok); end
        wait_done(lat);
        checks++; if (lat !== 5) begin failures++; $display("FAIL basic_latency got=%0d exp=5", lat); end
        checks++; if (bus.min_val !== 8'd0) begin failures++; $display("FAIL basic_min_val got=%0d exp=0", bus.min_val); end
        checks++; if (bus.min_pos !== 32'd3) begin failures++; $display("FAIL basic_min_pos got=%0d exp=3", bus.min_pos); end
        @(negedge clk);
        checks++; if (done_cnt - d0 !== 1) begin failures++; $display("FAIL basic_done_count got=%0d exp=1", done_cnt - d0); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL basic_busy_after got=%b exp=0", bus.busy); end
        checks++; if (bus.min_pos !== 32'd3) begin failures++; $display("FAIL basic_min_pos_held got=%0d exp=3", bus.min_pos); end
    endtask

    task automatic test_tie_break();
        bit ok; int lat;
        qv = '{8'd4, 8'd0, 8'd0, 8'd0};
        rv = '{8'd4, 8'd7, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        clear_gaps();
        do_start(1, 3);
        load_q(1, 0, ok);
        send_refs(3, ok);
        wait_done(lat);
        checks++; if (lat !== 3) begin failures++; $display("FAIL tie_latency got=%0d exp=3", lat); end
        checks++; if (bus.min_val !== 8'd0) begin failures++; $display("FAIL tie_min_val got=%0d exp=0", bus.min_val); end
        checks++; if (bus.min_pos !== 32'd0) begin failures++; $display("FAIL tie_min_pos got=%0d exp=0", bus.min_pos); end
        @(negedge clk);
    endtask

    task automatic test_saturation();
        bit ok; int lat;
        qv = '{8'd0, 8'd0, 8'd0, 8'd0};
        rv = '{8'd255, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        clear_gaps();
        do_start(2, 2);
        load_q(2, 0, ok);
        send_refs(2, ok);
        wait_done(lat);
        checks++; if (lat !== 4) begin failures++; $display("FAIL sat_latency got=%0d exp=4", lat); end
        checks++; if (bus.min_val !== 8'd255) begin failures++; $display("FAIL sat_min_val got=%0d exp=255", bus.min_val); end
        checks++; if (bus.min_pos !== 32'd0) begin failures++; $display("FAIL sat_min_pos got=%0d exp=0", bus.min_pos); end
        @(negedge clk);
    endtask

    task automatic test_stall();
        bit ok; int lat;
        set_basic();
        gv = '{0, 2, 1, 0, 3, 0, 0, 0};
        do_start(3, 5);
        load_q(3, 2, ok);
        send_refs(5, ok);
        wait_done(lat);
        checks++; if (lat !== 5) begin failures++; $display("FAIL stall_latency got=%0d exp=5", lat); end
        checks++; if (bus.min_val !== 8'd0) begin failures++; $display("FAIL stall_min_val got=%0d exp=0", bus.min_val); end
        checks++; if (bus.min_pos !== 32'd3) begin failures++; $display("FAIL stall_min_pos got=%0d exp=3", bus.min_pos); end
`ifdef SDTW_STALL_CNT_EN
        checks++; if (bus.stall_cycles !== 32'd6) begin failures++; $display("FAIL stall_cycles got=%0d exp=6", bus.stall_cycles); end
`endif
        @(negedge clk);
    endtask

    task automatic test_start_reject();
        int ql [3];
        int rl [3];
        ql = '{0, MAX_QLEN + 1, 3};
        rl = '{5, 5, 0};
        for (int i = 0; i < 3; i++) begin
            do_start(ql[i], rl[i]);
            checks++; if (bus.err !== 1'b1) begin failures++; $display("FAIL reject_err_%0d got=%b exp=1", i, bus.err); end
            checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reject_busy_%0d got=%b exp=0", i, bus.busy); end
            @(negedge clk);
            checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL reject_err_clear_%0d got=%b exp=0", i, bus.err); end
        end
    endtask

    task automatic test_start_while_busy();
        bit ok; int lat, e0;
        set_basic();
        e0 = err_cnt;
        do_start(3, 5);
        bus.start = 1; bus.q_len = QLW'(1); bus.r_len = 1;
        load_q(3, 0, ok);
        bus.start = 0;
        send_refs(5, ok);
        wait_done(lat);
        checks++; if (lat !== 5) begin failures++; $display("FAIL busy_start_latency got=%0d exp=5", lat); end
        checks++; if (bus.min_val !== 8'd0) begin failures++; $display("FAIL busy_start_min_val got=%0d exp=0", bus.min_val); end
        checks++; if (bus.min_pos !== 32'd3) begin failures++; $display("FAIL busy_start_min_pos got=%0d exp=3", bus.min_pos); end
        checks++; if (err_cnt - e0 !== 0) begin failures++; $display("FAIL busy_start_err got=%0d exp=0", err_cnt - e0); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_job();
        bit ok; int lat, d0;
        set_basic();
        d0 = done_cnt;
        do_start(3, 5);
        load_q(3, 0, ok);
        send_refs(2, ok);
        rst = 1;
        @(negedge clk);
        rst = 0;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.r_ready !== 1'b0) begin failures++; $display("FAIL midrst_r_ready got=%b exp=0", bus.r_ready); end
        checks++; if (bus.min_val !== INF) begin failures++; $display("FAIL midrst_min_val got=%0d exp=%0d", bus.min_val, INF); end
        checks++; if (bus.min_pos !== 32'd0) begin failures++; $display("FAIL midrst_min_pos got=%0d exp=0", bus.min_pos); end
        repeat (8) @(negedge clk);
        checks++; if (done_cnt - d0 !== 0) begin failures++; $display("FAIL midrst_no_done got=%0d exp=0", done_cnt - d0); end
        do_start(3, 5);
        load_q(3, 0, ok);
        send_refs(5, ok);
        wait_done(lat);
        checks++; if (bus.min_val !== 8'd0) begin failures++; $display("FAIL midrst_rerun_min_val got=%0d exp=0", bus.min_val); end
        checks++; if (bus.min_pos !== 32'd3) begin failures++; $display("FAIL midrst_rerun_min_pos got=%0d exp=3", bus.min_pos); end
        @(negedge clk);
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_basic_match();
        test_tie_break();
        test_saturation();
        test_stall();
        test_start_reject();
        test_start_while_busy();
        test_reset_mid_job();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
